i2c_target_regfile: RTL and testbench

// - I2C target (responder) with a byte-wide register file: the bus-side partner of our I2C initiator/Wishbone front end.
// - Samples raw SCL/SDA and detects START/STOP; decodes the 7-bit device address; ACKs, writes and reads bytes.
// - Drives SDA open-drain: it only ever pulls the line low.
// - Sits in the bench/SoC as the addressed device on the same bus as the initiator.

---
 rtl/i2c_target_regfile.sv | 172 +++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target with a byte-wide register file
// Samples raw SCL/SDA, decodes the device address and services pointer/write/read transfers.
module i2c_target_regfile #(
   parameter logic [6:0] DEV_ADDR    = 7'h50,
   parameter int         MEM_DEPTH   = 128,
   parameter int         SYNC_STAGES = 2,
   localparam int        PW          = $clog2(MEM_DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          scl_i,
   input  logic          sda_i,
   output logic          sda_o,
   output logic          sda_o_en,
   output logic          busy,
   output logic          wr_valid,
   output logic [PW-1:0] wr_addr,
   output logic [7:0]    wr_data
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_d;
   logic                   sda_d;
   logic                   scl_s;
   logic                   sda_s;
   logic                   scl_rise;
   logic                   scl_fall;
   logic                   start_det;
   logic                   stop_det;
   logic [3:0]             cnt;
   logic [7:0]             shreg;
   logic [7:0]             tx;
   logic                   rw;
   logic [PW-1:0]          ptr;
   logic [PW-1:0]          ptr_next;
   logic [7:0]             mem [MEM_DEPTH];

   assign sda_o = 1'b0;

   // Synchronizers idle high so a reset never fabricates a START/STOP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
         scl_d    <= scl_s;
         sda_d    <= sda_s;
      end
   end

   assign scl_s     = scl_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_d;
   assign scl_fall  = ~scl_s & scl_d;
   assign start_det = scl_s & scl_d & sda_d & ~sda_s;
   assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
   assign ptr_next  = (ptr == PW'(MEM_DEPTH - 1)) ? '0 : ptr + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         sda_o_en <= 1'b0;
         busy     <= 1'b0;
         wr_valid <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= 8'h00;
         cnt      <= 4'd0;
         shreg    <= 8'h00;
         tx       <= 8'h00;
         rw       <= 1'b0;
         ptr      <= '0;
         for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 8'h00;
      end else begin
         wr_valid <= 1'b0;
         if (start_det) begin
            state    <= ADDR;
            cnt      <= 4'd0;
            sda_o_en <= 1'b0;
         end else if (stop_det) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            sda_o_en <= 1'b0;
            busy     <= 1'b0;
         end else begin
            if (scl_rise && (state == ADDR || state == PTR || state == WDATA) && cnt != 4'd8) begin
               shreg <= {shreg[6:0], sda_s};
               cnt   <= cnt + 4'd1;
            end
            if (scl_rise && state == RDATA_ACK && sda_s)
               state <= WAIT;
            if (scl_fall) begin
               case (state)
                  ADDR: if (cnt == 4'd8) begin
                     cnt <= 4'd0;
                     if (shreg[7:1] == DEV_ADDR) begin
                        sda_o_en <= 1'b1;
                        busy     <= 1'b1;
                        rw       <= shreg[0];
                        state    <= ADDR_ACK;
                     end else begin
                        busy  <= 1'b0;
                        state <= WAIT;
                     end
                  end
                  ADDR_ACK: begin
                     if (!rw) begin
                        sda_o_en <= 1'b0;
                        state    <= PTR;
                     end else begin
                        tx       <= mem[ptr];
                        sda_o_en <= ~mem[ptr][7];
                        cnt      <= 4'd1;
                        state    <= RDATA;
                     end
                  end
                  PTR: if (cnt == 4'd8) begin
                     cnt      <= 4'd0;
                     ptr      <= shreg[PW-1:0];
                     sda_o_en <= 1'b1;
                     state    <= PTR_ACK;
                  end
                  PTR_ACK, WDATA_ACK: begin
                     sda_o_en <= 1'b0;
                     state    <= WDATA;
                  end
                  WDATA: if (cnt == 4'd8) begin
                     cnt      <= 4'd0;
                     mem[ptr] <= shreg;
                     wr_valid <= 1'b1;
                     wr_addr  <= ptr;
                     wr_data  <= shreg;
                     ptr      <= ptr_next;
                     sda_o_en <= 1'b1;
                     state    <= WDATA_ACK;
                  end
                  // tx[6] is always the next bit to present; cnt counts bits already driven.
                  RDATA: begin
                     if (cnt == 4'd8) begin
                        cnt      <= 4'd0;
                        sda_o_en <= 1'b0;
                        ptr      <= ptr_next;
                        state    <= RDATA_ACK;
                     end else begin
                        sda_o_en <= ~tx[6];
                        tx       <= {tx[6:0], 1'b0};
                        cnt      <= cnt + 4'd1;
                     end
                  end
                  RDATA_ACK: begin
                     tx       <= mem[ptr];
                     sda_o_en <= ~mem[ptr][7];
                     cnt      <= 4'd1;
                     state    <= RDATA;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb/tb_i2c_target_regfile.sv - directed bench for i2c_target_regfile
// Open-drain bus model with a bit-banged initiator; one task per scenario.
module tb_i2c_target_regfile;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_line;
   logic       sda_o;
   logic       sda_o_en;
   logic       busy;
   logic       wr_valid;
   logic [6:0] wr_addr;
   logic [7:0] wr_data;

   int         n_vec = 0;
   int         n_err = 0;
   int         wr_cnt = 0;
   int         en_cnt = 0;
   int         busy_cnt = 0;
   logic [6:0] last_addr = 7'h00;
   logic [7:0] last_data = 8'h00;

   assign sda_line = sda_m & ~sda_o_en;

   always #5 clk = ~clk;

   i2c_target_regfile dut (
      .clk(clk),
      .rst(rst),
      .scl_i(scl),
      .sda_i(sda_line),
      .sda_o(sda_o),
      .sda_o_en(sda_o_en),
      .busy(busy),
      .wr_valid(wr_valid),
      .wr_addr(wr_addr),
      .wr_data(wr_data)
   );

   always @(negedge clk) begin
      if (wr_valid) begin
         wr_cnt++;
         last_addr = wr_addr;
         last_data = wr_data;
      end
      if (sda_o_en) en_cnt++;
      if (busy) busy_cnt++;
   end

   task automatic q();
      #80;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; q();
      scl = 1'b1;   q();
      sda_m = 1'b0; q();
      scl = 1'b0;   q();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; q();
      scl = 1'b1;   q();
      sda_m = 1'b1; q();
   endtask

   task automatic send_bit(input logic b);
      sda_m = b; q();
      scl = 1'b1; q(); q();
      scl = 1'b0; q();
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      sda_m = 1'b1; q();
      scl = 1'b1;   q();
      ack = sda_line; q();
      scl = 1'b0;   q();
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d);
      for (int i = 7; i >= 0; i--) begin
         sda_m = 1'b1; q();
         scl = 1'b1;   q();
         d[i] = sda_line; q();
         scl = 1'b0;   q();
      end
      send_bit(nack);
   endtask

   task automatic read_at(input logic [7:0] p, output logic [7:0] d);
      logic a;
      i2c_start();
      write_byte(8'hA0, a);
      write_byte(p, a);
      i2c_start();
      write_byte(8'hA1, a);
      read_byte(1'b1, d);
      i2c_stop();
   endtask

   task automatic test_reset();
      n_vec++; if (sda_o_en !== 1'b0) begin n_err++; $display("FAIL reset_sda_o_en got %b want 0", sda_o_en); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
      n_vec++; if (wr_valid !== 1'b0) begin n_err++; $display("FAIL reset_wr_valid got %b want 0", wr_valid); end
      n_vec++; if (wr_addr !== 7'h00) begin n_err++; $display("FAIL reset_wr_addr got %h want 00", wr_addr); end
      n_vec++; if (wr_data !== 8'h00) begin n_err++; $display("FAIL reset_wr_data got %h want 00", wr_data); end
      n_vec++; if (sda_o !== 1'b0) begin n_err++; $display("FAIL sda_o_tied got %b want 0", sda_o); end
   endtask

   task automatic test_write();
      logic a0, a1, a2;
      int   w0;
      w0 = wr_cnt;
      i2c_start();
      write_byte(8'hA0, a0);
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL write_busy_set got %b want 1", busy); end
      write_byte(8'h10, a1);
      write_byte(8'hA5, a2);
      n_vec++; if ({a0, a1, a2} !== 3'b000) begin n_err++; $display("FAIL write_acks got %b want 000", {a0, a1, a2}); end
      n_vec++; if (wr_cnt - w0 !== 1) begin n_err++; $display("FAIL write_count got %0d want 1", wr_cnt - w0); end
      n_vec++; if (last_addr !== 7'h10) begin n_err++; $display("FAIL write_addr got %h want 10", last_addr); end
      n_vec++; if (last_data !== 8'hA5) begin n_err++; $display("FAIL write_data got %h want a5", last_data); end
      i2c_stop();
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL write_busy_clear got %b want 0", busy); end
   endtask

   task automatic test_read();
      logic       a;
      logic [7:0] d;
      i2c_start();
      write_byte(8'hA0, a);
      write_byte(8'h10, a);
      i2c_start();
      write_byte(8'hA1, a);
      n_vec++; if (a !== 1'b0) begin n_err++; $display("FAIL read_addr_ack got %b want 0", a); end
      read_byte(1'b1, d);
      n_vec++; if (d !== 8'hA5) begin n_err++; $display("FAIL read_data got %h want a5", d); end
      n_vec++; if (sda_o_en !== 1'b0) begin n_err++; $display("FAIL read_release got %b want 0", sda_o_en); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL read_busy got %b want 1", busy); end
      i2c_stop();
   endtask

   task automatic test_mismatch();
      logic       a;
      logic [7:0] d;
      int         e0, b0, w0;
      e0 = en_cnt; b0 = busy_cnt; w0 = wr_cnt;
      i2c_start();
      write_byte(8'hA2, a);
      n_vec++; if (a !== 1'b1) begin n_err++; $display("FAIL mismatch_nack got %b want 1", a); end
      write_byte(8'h10, a);
      write_byte(8'h5A, a);
      i2c_stop();
      n_vec++; if (en_cnt !== e0) begin n_err++; $display("FAIL mismatch_sda_en got %0d want %0d", en_cnt, e0); end
      n_vec++; if (busy_cnt !== b0) begin n_err++; $display("FAIL mismatch_busy got %0d want %0d", busy_cnt, b0); end
      n_vec++; if (wr_cnt !== w0) begin n_err++; $display("FAIL mismatch_write got %0d want %0d", wr_cnt, w0); end
      read_at(8'h10, d);
      n_vec++; if (d !== 8'hA5) begin n_err++; $display("FAIL mismatch_mem got %h want a5", d); end
   endtask

   task automatic test_wrap();
      logic       a;
      logic [7:0] d0, d1;
      int         w0;
      w0 = wr_cnt;
      i2c_start();
      write_byte(8'hA0, a);
      write_byte(8'h7F, a);
      write_byte(8'h11, a);
      write_byte(8'h22, a);
      i2c_stop();
      n_vec++; if (wr_cnt - w0 !== 2) begin n_err++; $display("FAIL wrap_count got %0d want 2", wr_cnt - w0); end
      n_vec++; if (last_addr !== 7'h00) begin n_err++; $display("FAIL wrap_addr got %h want 00", last_addr); end
      n_vec++; if (last_data !== 8'h22) begin n_err++; $display("FAIL wrap_data got %h want 22", last_data); end
      i2c_start();
      write_byte(8'hA0, a);
      write_byte(8'h7F, a);
      i2c_start();
      write_byte(8'hA1, a);
      read_byte(1'b0, d0);
      read_byte(1'b1, d1);
      i2c_stop();
      n_vec++; if (d0 !== 8'h11) begin n_err++; $display("FAIL wrap_read0 got %h want 11", d0); end
      n_vec++; if (d1 !== 8'h22) begin n_err++; $display("FAIL wrap_read1 got %h want 22", d1); end
   endtask

   task automatic test_abort();
      logic       a;
      logic [7:0] d;
      int         w0;
      w0 = wr_cnt;
      i2c_start();
      write_byte(8'hA0, a);
      write_byte(8'h30, a);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      i2c_stop();
      n_vec++; if (wr_cnt !== w0) begin n_err++; $display("FAIL abort_no_write got %0d want %0d", wr_cnt, w0); end
      n_vec++; if (sda_o_en !== 1'b0) begin n_err++; $display("FAIL abort_release got %b want 0", sda_o_en); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", busy); end
      i2c_start();
      write_byte(8'hA0, a);
      write_byte(8'h30, a);
      write_byte(8'hC3, a);
      i2c_stop();
      n_vec++; if (wr_cnt - w0 !== 1) begin n_err++; $display("FAIL abort_next_count got %0d want 1", wr_cnt - w0); end
      n_vec++; if ({last_addr, last_data} !== {7'h30, 8'hC3}) begin n_err++; $display("FAIL abort_next_write got %h/%h want 30/c3", last_addr, last_data); end
      read_at(8'h30, d);
      n_vec++; if (d !== 8'hC3) begin n_err++; $display("FAIL abort_readback got %h want c3", d); end
   endtask

   task automatic test_reset_mid_read();
      logic       a;
      logic [7:0] d;
      i2c_start();
      write_byte(8'hA0, a);
      write_byte(8'h7F, a);
      i2c_start();
      write_byte(8'hA1, a);
      q();
      n_vec++; if (sda_o_en !== 1'b1) begin n_err++; $display("FAIL midread_driving got %b want 1", sda_o_en); end
      rst = 1'b1;
      #1;
      n_vec++; if (sda_o_en !== 1'b0) begin n_err++; $display("FAIL midread_release got %b want 0", sda_o_en); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midread_busy got %b want 0", busy); end
      #40;
      rst = 1'b0;
      #9;
      i2c_stop();
      i2c_start();
      write_byte(8'hA1, a);
      n_vec++; if (a !== 1'b0) begin n_err++; $display("FAIL postreset_ack got %b want 0", a); end
      read_byte(1'b1, d);
      i2c_stop();
      n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL postreset_ptr0 got %h want 00", d); end
      read_at(8'h7F, d);
      n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL postreset_mem got %h want 00", d); end
   endtask

   initial begin
      #32;
      rst = 1'b0;
      #50;
      test_reset();
      test_write();
      test_read();
      test_mismatch();
      test_wrap();
      test_abort();
      test_reset_mid_read();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
